// File: rtl/llc_bus_agent_pkg.sv
// Shared bus types and helpers for the LLC bus agent: op and snoop encodings,
// FSM states, and the snoop merge/model functions.
package llc_bus_agent_pkg;

  localparam int OP_W    = 3;
  localparam int SNOOP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NONE       = 3'b000,
    OP_READ       = 3'b001,
    OP_WRITE      = 3'b010,
    OP_INVALIDATE = 3'b011,
    OP_RWIM       = 3'b100
  } bus_operation_e;

  typedef enum logic [SNOOP_W-1:0] {
    SNOOP_HIT   = 2'b00,
    SNOOP_HITM  = 2'b01,
    SNOOP_NOHIT = 2'b10
  } snoop_result_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_SNOOP = 2'd2,
    ST_RESP  = 2'd3
  } agent_state_e;

  // Priority HITM > HIT > NOHIT; the unused 2'b11 code falls through as NOHIT.
  function automatic logic [SNOOP_W-1:0] snoop_merge(input logic [SNOOP_W-1:0] a,
                                                     input logic [SNOOP_W-1:0] b);
    if (a == SNOOP_HITM || b == SNOOP_HITM)
      return SNOOP_HITM;
    else if (a == SNOOP_HIT || b == SNOOP_HIT)
      return SNOOP_HIT;
    else
      return SNOOP_NOHIT;
  endfunction

  function automatic logic [SNOOP_W-1:0] snoop_model(input logic [1:0] addr_lsb);
    case (addr_lsb)
      2'b00:   return SNOOP_HIT;
      2'b01:   return SNOOP_HITM;
      default: return SNOOP_NOHIT;
    endcase
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_READ) || (op == OP_WRITE) || (op == OP_INVALIDATE) || (op == OP_RWIM);
  endfunction

endpackage

// File: rtl/llc_bus_agent_collector.sv
// Sticky per-snooper capture of snoop responses with a combinational merge
// that also folds in responses arriving in the current cycle.
module llc_snoop_collector
  import llc_bus_agent_pkg::*;
#(
  parameter int NUM_SNOOPERS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        enable,
  input  logic [NUM_SNOOPERS-1:0]     snoop_valid,
  input  logic [2*NUM_SNOOPERS-1:0]   snoop_result,
  output logic                        all_seen,
  output logic [SNOOP_W-1:0]          merged
);

  logic [NUM_SNOOPERS-1:0]   seen;
  logic [2*NUM_SNOOPERS-1:0] cap;

  // First strobe per snooper wins; later strobes from the same snooper are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      seen <= '0;
      cap  <= '0;
    end else if (enable) begin
      for (int i = 0; i < NUM_SNOOPERS; i++) begin
        if (snoop_valid[i] && !seen[i]) begin
          seen[i]        <= 1'b1;
          cap[2*i +: 2]  <= snoop_result[2*i +: 2];
        end
      end
    end
  end

  always_comb begin
    merged   = SNOOP_NOHIT;
    all_seen = 1'b1;
    for (int i = 0; i < NUM_SNOOPERS; i++) begin
      if (seen[i])
        merged = snoop_merge(merged, cap[2*i +: 2]);
      else if (enable && snoop_valid[i])
        merged = snoop_merge(merged, snoop_result[2*i +: 2]);
      else
        all_seen = 1'b0;
    end
  end

endmodule

// File: rtl/llc_bus_agent.sv
// LLC-side bus agent: issues one bus op at a time, collects snoop results from
// peer caches, returns one merged response and keeps saturating op statistics.
module llc_bus_agent
  import llc_bus_agent_pkg::*;
#(
  parameter int         ADDR_W        = 32,
  parameter int         NUM_SNOOPERS  = 4,
  parameter int         SNOOP_TIMEOUT = 8,
  parameter int         CNT_W         = 32,
  parameter logic [3:0] CACHE_ID      = 4'h0,
  parameter bit         SNOOP_MODEL   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [OP_W-1:0]            req_op,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       rsp_valid,
  output logic [SNOOP_W-1:0]         rsp_snoop,
  output logic                       rsp_timeout,
  output logic                       rsp_err,
  output logic                       bus_valid,
  output logic [OP_W-1:0]            bus_op,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [3:0]                 bus_cache_id,
  input  logic [NUM_SNOOPERS-1:0]    snoop_valid,
  input  logic [2*NUM_SNOOPERS-1:0]  snoop_result,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           rd_cnt,
  output logic [CNT_W-1:0]           wr_cnt,
  output logic [CNT_W-1:0]           inv_cnt
);

  localparam int               TO_W    = $clog2(SNOOP_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(SNOOP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  agent_state_e       state;
  logic [TO_W-1:0]    to_cnt;
  logic               all_seen;
  logic [SNOOP_W-1:0] merged;
  logic               issuing;

  assign issuing = (state == ST_ISSUE);

  llc_snoop_collector #(
    .NUM_SNOOPERS (NUM_SNOOPERS)
  ) u_collector (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (issuing),
    .enable       (state == ST_SNOOP),
    .snoop_valid  (snoop_valid),
    .snoop_result (snoop_result),
    .all_seen     (all_seen),
    .merged       (merged)
  );

  // Main FSM; every output is registered and the rsp_* strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_snoop    <= '0;
      rsp_timeout  <= 1'b0;
      rsp_err      <= 1'b0;
      bus_valid    <= 1'b0;
      bus_op       <= '0;
      bus_addr     <= '0;
      bus_cache_id <= '0;
      to_cnt       <= '0;
    end else begin
      bus_cache_id <= CACHE_ID;
      bus_valid    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_snoop    <= '0;
      rsp_timeout  <= 1'b0;
      rsp_err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (op_legal(req_op)) begin
              state     <= ST_ISSUE;
              bus_valid <= 1'b1;
              bus_op    <= req_op;
              bus_addr  <= req_addr;
            end else begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_snoop <= SNOOP_NOHIT;
            end
          end
        end
        ST_ISSUE: begin
          to_cnt <= '0;
          if (bus_op == OP_WRITE) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_snoop <= SNOOP_NOHIT;
          end else if (SNOOP_MODEL) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_snoop <= snoop_model(bus_addr[1:0]);
          end else begin
            state <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          if (all_seen) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_snoop <= merged;
          end else if (to_cnt == TO_LAST) begin
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            rsp_snoop   <= merged;
            rsp_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Statistics count during ISSUE; a same-cycle clear drops the increment.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      inv_cnt <= '0;
    end else if (issuing) begin
      if ((bus_op == OP_READ || bus_op == OP_RWIM) && rd_cnt != CNT_MAX)
        rd_cnt <= rd_cnt + 1'b1;
      if (bus_op == OP_WRITE && wr_cnt != CNT_MAX)
        wr_cnt <= wr_cnt + 1'b1;
      if (bus_op == OP_INVALIDATE && inv_cnt != CNT_MAX)
        inv_cnt <= inv_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_llc_bus_agent.sv
// Directed bench for llc_bus_agent: a snooping instance and a model-mode
// instance with narrow counters, checked with immediate assertions.
module tb_llc_bus_agent;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // Snooping instance
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_timeout, rsp_err, bus_valid, stat_clr;
  logic [1:0]  rsp_snoop;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic [3:0]  bus_cache_id;
  logic [3:0]  snoop_valid;
  logic [7:0]  snoop_result;
  logic [31:0] rd_cnt, wr_cnt, inv_cnt;

  // Model-mode instance with 4-bit counters
  logic        m_req_valid, m_req_ready;
  logic [2:0]  m_req_op;
  logic [31:0] m_req_addr;
  logic        m_rsp_valid, m_rsp_timeout, m_rsp_err, m_bus_valid;
  logic [1:0]  m_rsp_snoop;
  logic [2:0]  m_bus_op;
  logic [31:0] m_bus_addr;
  logic [3:0]  m_bus_cache_id;
  logic [3:0]  m_snoop_valid = 4'h0;
  logic [7:0]  m_snoop_result = 8'h00;
  logic        m_stat_clr = 1'b0;
  logic [3:0]  m_rd_cnt, m_wr_cnt, m_inv_cnt;

  always #5 clk = ~clk;

  llc_bus_agent #(
    .ADDR_W(32), .NUM_SNOOPERS(4), .SNOOP_TIMEOUT(8), .CNT_W(32),
    .CACHE_ID(4'hA), .SNOOP_MODEL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_snoop(rsp_snoop), .rsp_timeout(rsp_timeout), .rsp_err(rsp_err),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_cache_id(bus_cache_id),
    .snoop_valid(snoop_valid), .snoop_result(snoop_result), .stat_clr(stat_clr),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .inv_cnt(inv_cnt)
  );

  llc_bus_agent #(
    .ADDR_W(32), .NUM_SNOOPERS(4), .SNOOP_TIMEOUT(8), .CNT_W(4),
    .CACHE_ID(4'h3), .SNOOP_MODEL(1'b1)
  ) dut_model (
    .clk(clk), .rst_n(rst_n),
    .req_valid(m_req_valid), .req_ready(m_req_ready), .req_op(m_req_op), .req_addr(m_req_addr),
    .rsp_valid(m_rsp_valid), .rsp_snoop(m_rsp_snoop), .rsp_timeout(m_rsp_timeout), .rsp_err(m_rsp_err),
    .bus_valid(m_bus_valid), .bus_op(m_bus_op), .bus_addr(m_bus_addr), .bus_cache_id(m_bus_cache_id),
    .snoop_valid(m_snoop_valid), .snoop_result(m_snoop_result), .stat_clr(m_stat_clr),
    .rd_cnt(m_rd_cnt), .wr_cnt(m_wr_cnt), .inv_cnt(m_inv_cnt)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] addr);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
  endtask

  // Model-mode op: request at T, bus strobe at T+1, response at T+2, idle again at T+3.
  task automatic model_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [1:0] exp_snoop);
    m_req_valid = 1'b1;
    m_req_op    = op;
    m_req_addr  = addr;
    next_cycle();
    m_req_valid = 1'b0;
    check_output({tag, "_bus_valid"}, {31'd0, m_bus_valid}, 32'd1);
    next_cycle();
    check_output({tag, "_rsp_valid"}, {31'd0, m_rsp_valid}, 32'd1);
    check_output({tag, "_rsp_snoop"}, {30'd0, m_rsp_snoop}, {30'd0, exp_snoop});
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0; stat_clr = 1'b0;
    req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0;
    snoop_valid = 4'h0; snoop_result = 8'h00;
    m_req_valid = 1'b0; m_req_op = 3'd0; m_req_addr = 32'd0;

    repeat (2) next_cycle();
    check_output("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check_output("rst_rd_cnt", rd_cnt, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // READ, all four snoopers answer in the first SNOOP cycle
    apply_stimulus(3'b001, 32'h1000_0040);
    next_cycle();
    req_valid = 1'b0;
    check_output("rd_bus_valid", {31'd0, bus_valid}, 32'd1);
    check_output("rd_bus_op", {29'd0, bus_op}, 32'd1);
    check_output("rd_bus_addr", bus_addr, 32'h1000_0040);
    check_output("rd_bus_cache_id", {28'd0, bus_cache_id}, 32'hA);
    check_output("rd_req_ready", {31'd0, req_ready}, 32'd0);
    next_cycle();
    check_output("rd_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
    snoop_valid = 4'hF; snoop_result = 8'b01_10_00_10;
    next_cycle();
    snoop_valid = 4'h0;
    check_output("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_output("rd_rsp_snoop", {30'd0, rsp_snoop}, 32'd1);
    check_output("rd_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check_output("rd_cnt_1", rd_cnt, 32'd1);
    next_cycle();
    check_output("rd_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    check_output("rd_ready_back", {31'd0, req_ready}, 32'd1);

    // RWIM, only snoopers 0 and 1 answer HIT; a repeat from snooper 0 is ignored
    apply_stimulus(3'b100, 32'h1000_0080);
    next_cycle();
    req_valid = 1'b0;
    check_output("rwim_bus_op", {29'd0, bus_op}, 32'd4);
    next_cycle();
    snoop_valid = 4'b0011; snoop_result = 8'b10_10_00_00;
    next_cycle();
    snoop_valid = 4'b0001; snoop_result = 8'b10_10_00_01;
    next_cycle();
    snoop_valid = 4'h0;
    repeat (5) next_cycle();
    check_output("rwim_t9_no_rsp", {31'd0, rsp_valid}, 32'd0);
    next_cycle();
    check_output("rwim_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_output("rwim_rsp_snoop", {30'd0, rsp_snoop}, 32'd0);
    check_output("rwim_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    check_output("rwim_rd_cnt", rd_cnt, 32'd2);
    next_cycle();
    check_output("rwim_timeout_drop", {31'd0, rsp_timeout}, 32'd0);

    // WRITE with snoop strobes that must be ignored
    apply_stimulus(3'b010, 32'h2000_0000);
    snoop_valid = 4'hF; snoop_result = 8'h55;
    next_cycle();
    req_valid = 1'b0;
    check_output("wr_bus_op", {29'd0, bus_op}, 32'd2);
    next_cycle();
    snoop_valid = 4'h0;
    check_output("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_output("wr_rsp_snoop", {30'd0, rsp_snoop}, 32'd2);
    next_cycle();
    check_output("wr_cnt_1", wr_cnt, 32'd1);
    check_output("wr_ready_back", {31'd0, req_ready}, 32'd1);

    // INVALIDATE with snoopers answering over two cycles
    apply_stimulus(3'b011, 32'h3000_0000);
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    snoop_valid = 4'b0011; snoop_result = 8'hAA;
    next_cycle();
    check_output("inv_partial_no_rsp", {31'd0, rsp_valid}, 32'd0);
    snoop_valid = 4'b1100; snoop_result = 8'b10_01_10_10;
    next_cycle();
    snoop_valid = 4'h0;
    check_output("inv_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_output("inv_rsp_snoop", {30'd0, rsp_snoop}, 32'd1);
    check_output("inv_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check_output("inv_cnt_1", inv_cnt, 32'd1);
    next_cycle();

    // WRITE with stat_clr during ISSUE: clear wins over increment
    apply_stimulus(3'b010, 32'h2000_0100);
    next_cycle();
    req_valid = 1'b0;
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    check_output("clr_wr_cnt", wr_cnt, 32'd0);
    check_output("clr_rd_cnt", rd_cnt, 32'd0);
    next_cycle();

    // Illegal op 3'b111
    apply_stimulus(3'b111, 32'h4000_0000);
    next_cycle();
    req_valid = 1'b0;
    check_output("ill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_output("ill_rsp_err", {31'd0, rsp_err}, 32'd1);
    check_output("ill_rsp_snoop", {30'd0, rsp_snoop}, 32'd2);
    check_output("ill_no_bus_valid", {31'd0, bus_valid}, 32'd0);
    next_cycle();
    check_output("ill_err_drop", {31'd0, rsp_err}, 32'd0);
    check_output("ill_ready_back", {31'd0, req_ready}, 32'd1);
    check_output("ill_no_count", wr_cnt, 32'd0);

    // Reset during SNOOP aborts silently
    apply_stimulus(3'b001, 32'h1000_0000);
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    check_output("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check_output("abort_rd_cnt", rd_cnt, 32'd0);
    check_output("abort_inv_cnt", inv_cnt, 32'd0);
    next_cycle();
    check_output("abort_still_quiet", {31'd0, rsp_valid}, 32'd0);

    // Model-mode responses from address LSBs, then counter saturation
    model_op("mdl_00", 3'b001, 32'h5000_0000, 2'b00);
    model_op("mdl_01", 3'b001, 32'h5000_0001, 2'b01);
    model_op("mdl_10", 3'b001, 32'h5000_0002, 2'b10);
    check_output("mdl_rd_cnt", {28'd0, m_rd_cnt}, 32'd3);
    for (int i = 0; i < 16; i++)
      model_op("mdl_inv", 3'b011, 32'h6000_0000, 2'b00);
    check_output("mdl_inv_sat", {28'd0, m_inv_cnt}, 32'hF);
    check_output("mdl_timeout", {31'd0, m_rsp_timeout}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
